mo_from_mont: RTL and testbench

Iterative Montgomery-domain exit unit: the inverse end of `mo_mul`. It takes a signed residue in (−Q, Q) carrying a factor 2^SHIFT and returns the canonical value x·2^(−SHIFT) mod Q in [0, Q−1]. It uses valid/ready handshakes on both sides and one bit-serial halving step per cycle. It sits between the `mo_mul` datapath (NTT/pointwise output) and the packing/compress logic, which requires canonical coefficients.

---
 rtl/mo_pkg.sv | 15 +
 rtl/mo_half_step.sv | 21 ++
 rtl/mo_from_mont.sv | 116 +++++++++++
 tb/tb_mo_from_mont.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mo_pkg.sv
// Shared definitions for the Montgomery-domain exit/entry units.
package mo_pkg;

   // Modulus used by the NTT datapath
   localparam int unsigned MO_Q = 3329;

   // Exit-unit sequencing: load, bit-serial halving, sign fix, handoff
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HALVE = 2'd1,
      FIX   = 2'd2,
      DONE  = 2'd3
   } mo_exit_state_t;

endpackage

// File: rtl/mo_half_step.sv
// One Montgomery halving step: acc -> (acc - Q*acc[0]) >>> 1, i.e. acc * 2^-1 mod Q.
// Subtracting Q (odd) when acc is odd makes the value even, so the shift is exact.
module mo_half_step #(
   parameter int          WIDTH = 12,
   parameter int unsigned Q     = 3329
) (
   input  logic signed [WIDTH+1:0] acc_i,
   output logic signed [WIDTH+1:0] acc_o
);

   localparam logic signed [WIDTH+1:0] QS = (WIDTH+2)'(Q);

   logic signed [WIDTH+1:0] diff;

   // acc - Q lies in (-2Q, 0), which still fits in WIDTH+2 signed bits
   always_comb begin
      diff  = acc_i[0] ? (acc_i - QS) : acc_i;
      acc_o = diff >>> 1;
   end

endmodule

// File: rtl/mo_from_mont.sv
// Montgomery exit unit: x*2^SHIFT (signed, |x| < Q) -> canonical x mod Q in [0, Q-1].
// One operand in flight; valid/ready on both sides; one halving per cycle.
module mo_from_mont
   import mo_pkg::*;
#(
   parameter int          WIDTH = 12,
   parameter int          SHIFT = WIDTH,
   parameter int          TAG_W = 8,
   parameter int unsigned Q     = MO_Q
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH:0]   in_data_i,
   input  logic             in_norm_i,
   input  logic [TAG_W-1:0] in_tag_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_data_o,
   output logic [TAG_W-1:0] out_tag_o
);

   localparam int AW    = WIDTH + 2;
   localparam int CNT_W = (SHIFT > 1) ? $clog2(SHIFT) : 1;
   localparam logic signed [AW-1:0]  QS       = AW'(Q);
   localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(SHIFT - 1);

   mo_exit_state_t          state_q, state_d;
   logic signed [AW-1:0]    acc_q, acc_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [TAG_W-1:0]        tag_q, tag_d;
   logic                    out_valid_q, out_valid_d;
   logic [WIDTH-1:0]        out_data_q, out_data_d;
   logic [TAG_W-1:0]        out_tag_q, out_tag_d;
   logic signed [AW-1:0]    acc_half;
   logic signed [AW-1:0]    acc_fix;

   mo_half_step #(
      .WIDTH (WIDTH),
      .Q     (Q)
   ) u_half (
      .acc_i (acc_q),
      .acc_o (acc_half)
   );

   // Fold a negative residue into [0, Q-1]
   always_comb acc_fix = acc_q[AW-1] ? (acc_q + QS) : acc_q;

   // Next-state and datapath updates; outputs are only loaded on FIX -> DONE
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      tag_d       = tag_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_tag_d   = out_tag_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid_i) begin
               acc_d   = {in_data_i[WIDTH], in_data_i};
               tag_d   = in_tag_i;
               cnt_d   = '0;
               state_d = in_norm_i ? FIX : HALVE;
            end
         end
         HALVE: begin
            acc_d = acc_half;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) state_d = FIX;
         end
         FIX: begin
            acc_d       = acc_fix;
            out_data_d  = acc_fix[WIDTH-1:0];
            out_tag_d   = tag_q;
            out_valid_d = 1'b1;
            state_d     = DONE;
         end
         DONE: begin
            if (out_ready_i) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and handshake registers; reset drops any operand in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         tag_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_tag_q   <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         tag_q       <= tag_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_tag_q   <= out_tag_d;
      end
   end

   assign in_ready_o  = (state_q == IDLE);
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign out_tag_o   = out_tag_q;

endmodule

// File: tb/tb_mo_from_mont.sv
// Directed and random checks of the Montgomery exit unit (WIDTH=SHIFT=12, Q=3329).
module tb_mo_from_mont;

   localparam int WIDTH = 12;
   localparam int SHIFT = 12;
   localparam int TAG_W = 8;
   localparam int Q     = 3329;
   localparam int QINV  = 2704;   // 2^-12 mod 3329 (767*2704 = 623*3329 + 1)
   localparam int LAT_H = SHIFT + 2;
   localparam int LAT_N = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid_i = 1'b0;
   logic             in_ready_o;
   logic [WIDTH:0]   in_data_i = '0;
   logic             in_norm_i = 1'b0;
   logic [TAG_W-1:0] in_tag_i = '0;
   logic             out_valid_o;
   logic             out_ready_i = 1'b1;
   logic [WIDTH-1:0] out_data_o;
   logic [TAG_W-1:0] out_tag_o;

   int errors = 0;
   int checks = 0;

   mo_from_mont #(
      .WIDTH (WIDTH),
      .SHIFT (SHIFT),
      .TAG_W (TAG_W),
      .Q     (Q)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_data_i   (in_data_i),
      .in_norm_i   (in_norm_i),
      .in_tag_i    (in_tag_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (out_data_o),
      .out_tag_o   (out_tag_o)
   );

   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int             data;
      bit             norm;
      logic [7:0]     tag;
      int             exp_data;
      int             exp_lat;
   } vec_t;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Reference: canonical residue, then multiply by 2^-12 mod Q
   function automatic int ref_model(input int x, input bit norm);
      longint r;
      r = x % Q;
      if (r < 0) r += Q;
      if (!norm) r = (r * QINV) % Q;
      return int'(r);
   endfunction

   // Issue one operand, wait for the result, optionally stall the consumer
   task automatic run_op(input int data, input bit norm, input logic [7:0] tag,
                         input int stall, output int res, output int rtag, output int lat);
      int w;
      bit bad;
      @(negedge clk);
      in_data_i   = (WIDTH+1)'(data);
      in_norm_i   = norm;
      in_tag_i    = tag;
      in_valid_i  = 1'b1;
      out_ready_i = (stall == 0);
      w = 0;
      while (!in_ready_o && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready_o) chk("accept_timeout", in_ready_o, 1);
      @(posedge clk);
      @(negedge clk);
      in_valid_i = 1'b0;
      lat = 1;
      while (!out_valid_o && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      if (!out_valid_o) chk("result_timeout", out_valid_o, 1);
      res  = int'(out_data_o);
      rtag = int'(out_tag_o);
      if (stall > 0) begin
         bad = 1'b0;
         for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (!out_valid_o || in_ready_o || int'(out_data_o) != res || int'(out_tag_o) != rtag)
               bad = 1'b1;
         end
         chk("stall_stable", bad, 0);
      end
      out_ready_i = 1'b1;
      @(posedge clk);
   endtask

   vec_t tbl [10];

   initial begin
      int res, rtag, lat, exp;
      bit early;
      logic [7:0] t;

      tbl[0] = '{ 767,  1'b0, 8'h5A, 1,    LAT_H};
      tbl[1] = '{-767,  1'b0, 8'h11, 3328, LAT_H};
      tbl[2] = '{ 1534, 1'b0, 8'h22, 2,    LAT_H};
      tbl[3] = '{ 0,    1'b0, 8'h33, 0,    LAT_H};
      tbl[4] = '{ 1,    1'b0, 8'h44, 2704, LAT_H};
      tbl[5] = '{ 3328, 1'b0, 8'h55, 625,  LAT_H};
      tbl[6] = '{-1,    1'b0, 8'h66, 625,  LAT_H};
      tbl[7] = '{-1,    1'b1, 8'h77, 3328, LAT_N};
      tbl[8] = '{-3328, 1'b1, 8'h88, 1,    LAT_N};
      tbl[9] = '{ 3328, 1'b1, 8'h99, 3328, LAT_N};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready_o, 1);
      chk("rst_out_valid", out_valid_o, 0);
      chk("rst_out_data", out_data_o, 0);
      chk("rst_out_tag", out_tag_o, 0);
      rst_n = 1'b1;

      // Directed vectors
      for (int i = 0; i < 10; i++) begin
         run_op(tbl[i].data, tbl[i].norm, tbl[i].tag, 0, res, rtag, lat);
         chk($sformatf("vec%0d_data", i), res, tbl[i].exp_data);
         chk($sformatf("vec%0d_tag", i), rtag, tbl[i].tag);
         chk($sformatf("vec%0d_lat", i), lat, tbl[i].exp_lat);
      end

      // Back-pressure: 10 stalled cycles in DONE, then release
      run_op(767, 1'b0, 8'hC3, 10, res, rtag, lat);
      chk("bp_data", res, 1);
      chk("bp_tag", rtag, 8'hC3);
      #1;
      chk("bp_in_ready_after", in_ready_o, 1);
      chk("bp_out_valid_after", out_valid_o, 0);

      // Reset while halving (after 5 steps)
      @(negedge clk);
      in_data_i  = (WIDTH+1)'(767);
      in_norm_i  = 1'b0;
      in_tag_i   = 8'hE1;
      in_valid_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid_i = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", in_ready_o, 1);
      chk("midrst_out_valid", out_valid_o, 0);
      chk("midrst_out_data", out_data_o, 0);
      chk("midrst_out_tag", out_tag_o, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      early = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (out_valid_o || !in_ready_o) early = 1'b1;
      end
      chk("midrst_no_output", early, 0);
      run_op(767, 1'b0, 8'hE2, 0, res, rtag, lat);
      chk("midrst_next_data", res, 1);
      chk("midrst_next_tag", rtag, 8'hE2);
      chk("midrst_next_lat", lat, LAT_H);

      // Random sweep with consumer stalls
      for (int i = 0; i < 1500; i++) begin
         int  x;
         bit  nm;
         x  = int'($urandom_range(0, 2 * (Q - 1))) - (Q - 1);
         nm = ($urandom_range(0, 7) == 0);
         t  = 8'(i);
         run_op(x, nm, t, int'($urandom_range(0, 3)), res, rtag, lat);
         exp = ref_model(x, nm);
         chk($sformatf("rnd%0d_data(x=%0d,n=%0d)", i, x, nm), res, exp);
         chk($sformatf("rnd%0d_tag", i), rtag, t);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
